// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default sizes for the data-memory
// arbiter that sits between the CPU (port 0) and the host loader (port 1).
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arbState_t;

   localparam int DMEM_AW_DEFAULT = 8;
   localparam int DMEM_DW_DEFAULT = 8;

   // Width of the fairness counter; big enough for the largest hold limit.
   localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/arb_hold_ctr.sv
// arb_hold_ctr: fairness counter for the data-memory arbiter. It counts the
// cycles the current owner keeps the memory while the other port is waiting,
// and tells the arbiter when the owner has used up its turn.
module arb_hold_ctr
   import dmem_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
)
(
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  owned,
   input  logic                  otherReq,
   input  logic                  ownerChange,
   output logic [HOLD_CNT_W-1:0] holdCnt,
   output logic                  switchNow
);

   localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

   // The owner must hand over once it has held the memory MAX_HOLD cycles
   // while the other port was waiting.
   assign switchNow = owned & otherReq & (holdCnt == HOLD_LIMIT);

   // Restart on every ownership change; only contended cycles count, so an
   // uncontested owner keeps the memory for as long as it likes.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         holdCnt <= '0;
      end else if (ownerChange) begin
         holdCnt <= '0;
      end else if (owned && otherReq) begin
         holdCnt <= holdCnt + HOLD_CNT_W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port 0 is the CPU, port 1 the host loader. Grants are registered, the owner
// gets one access per cycle, and reads return registered data one cycle later.
// Optional feature macro DMEM_ARB_PERF_EN adds per-port wait-cycle counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = DMEM_AW_DEFAULT,
   parameter int DW       = DMEM_DW_DEFAULT,
   parameter int MAX_HOLD = 4
)
(
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          stall0,
   output logic [DW-1:0] rdata,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   input  logic          perf_clr,
   output logic [15:0]   wait_cnt0,
   output logic [15:0]   wait_cnt1
`endif
);

   arbState_t state;
   arbState_t nextState;
   logic      lastServed;
   logic      access0;
   logic      access1;
   logic      read0;
   logic      read1;
   logic      owned;
   logic      otherReq;
   logic      ownerChange;
   logic      switchNow;

   // Grants come straight from the registered state, so at most one is high.
   assign gnt0   = (state == OWN0);
   assign gnt1   = (state == OWN1);
   assign stall0 = req0 & ~gnt0;

   // An access only happens when the owner is actually requesting.
   assign access0 = gnt0 & req0;
   assign access1 = gnt1 & req1;
   assign read0   = access0 & ~we0;
   assign read1   = access1 & ~we1;

   assign owned       = (state != IDLE);
   assign otherReq    = gnt0 ? req1 : (gnt1 ? req0 : 1'b0);
   assign ownerChange = (nextState != state);

   arb_hold_ctr #(
      .MAX_HOLD (MAX_HOLD)
   ) uHoldCtr (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .owned       (owned),
      .otherReq    (otherReq),
      .ownerChange (ownerChange),
      .holdCnt     (),
      .switchNow   (switchNow)
   );

   // State register plus the last-served pointer used to break ties from IDLE.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         lastServed <= 1'b1;
      end else begin
         state <= nextState;
         if (nextState == OWN0) begin
            lastServed <= 1'b0;
         end else if (nextState == OWN1) begin
            lastServed <= 1'b1;
         end
      end
   end

   // Next-state choice and the memory-side mux driven from the current owner.
   always_comb begin
      nextState = state;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               nextState = lastServed ? OWN0 : OWN1;
            end else if (req0) begin
               nextState = OWN0;
            end else if (req1) begin
               nextState = OWN1;
            end
         end
         OWN0: begin
            if (!req0) begin
               nextState = req1 ? OWN1 : IDLE;
            end else if (switchNow) begin
               nextState = OWN1;
            end
         end
         OWN1: begin
            if (!req1) begin
               nextState = req0 ? OWN0 : IDLE;
            end else if (switchNow) begin
               nextState = OWN0;
            end
         end
         default: nextState = IDLE;
      endcase
      if (access0) begin
         mem_addr  = addr0;
         mem_we    = we0;
         mem_wdata = wdata0;
      end else if (access1) begin
         mem_addr  = addr1;
         mem_we    = we1;
         mem_wdata = wdata1;
      end
   end

   // Capture read data and flag it valid for the port that issued the read.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rdata   <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= read0;
         rvalid1 <= read1;
         if (read0 || read1) begin
            rdata <= mem_rdata;
         end
      end
   end

`ifdef DMEM_ARB_PERF_EN
   // Saturating counts of cycles each port spent requesting without a grant.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wait_cnt0 <= '0;
         wait_cnt1 <= '0;
      end else if (perf_clr) begin
         wait_cnt0 <= '0;
         wait_cnt1 <= '0;
      end else begin
         if (req0 && !gnt0 && (wait_cnt0 != 16'hFFFF)) begin
            wait_cnt0 <= wait_cnt0 + 16'd1;
         end
         if (req1 && !gnt1 && (wait_cnt1 != 16'hFFFF)) begin
            wait_cnt1 <= wait_cnt1 + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// reference model of ownership, fairness, memory contents and read returns.
// Covers wait counters when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

   localparam int AW       = 8;
   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;

   logic          Clk;
   logic          Reset_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, stall0;
   logic [DW-1:0] rdata;
   logic          rvalid0, rvalid1;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
   logic          perfClr;
   logic [15:0]   waitCnt0, waitCnt1;
`endif

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   int           mOwner;
   int           mLast;
   int           mStreak;
   logic         mRvalid0, mRvalid1;
   logic [DW-1:0] mRdata;
   int           mWait [2];
   logic [DW-1:0] refMem [256];

   // Memory attached to the arbiter
   logic [DW-1:0] mem [256];
   logic          memInit;

   dmem_arbiter #(
      .AW       (AW),
      .DW       (DW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .stall0    (stall0),
      .rdata     (rdata),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_clr  (perfClr),
      .wait_cnt0 (waitCnt0),
      .wait_cnt1 (waitCnt1)
`endif
   );

   // Free-running clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous-write, combinational-read memory model
   always @(posedge Clk) begin
      if (memInit) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   // Watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
      end
   endtask

   task automatic resetModel();
      mOwner   = -1;
      mLast    = 1;
      mStreak  = 0;
      mRvalid0 = 1'b0;
      mRvalid1 = 1'b0;
      mRdata   = '0;
      mWait[0] = 0;
      mWait[1] = 0;
   endtask

   // Assert reset off the clock edge, check the async reset values, release at negedge
   task automatic resetDut();
      Reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
`ifdef DMEM_ARB_PERF_EN
      perfClr = 1'b0;
`endif
      #1;
      checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
      checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
      checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
      checkOutput("rst_rvalid1", 32'(rvalid1), 32'd0);
      checkOutput("rst_rdata", 32'(rdata), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
`ifdef DMEM_ARB_PERF_EN
      checkOutput("rst_wait0", 32'(waitCnt0), 32'd0);
      checkOutput("rst_wait1", 32'(waitCnt1), 32'd0);
`endif
      resetModel();
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   // One clock cycle: drive inputs at negedge, check memory side, advance the
   // model, then check registered outputs at the following negedge.
   task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic clr);
      logic [1:0]    rq;
      logic [1:0]    wv;
      logic [AW-1:0] ad [2];
      logic [DW-1:0] dd [2];
      logic          acc;
      logic          expWe;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWdata;
      logic          nRv0, nRv1;
      int            o, p, nxt;
      req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
`ifdef DMEM_ARB_PERF_EN
      perfClr = clr;
`endif
      rq = {r1, r0};
      wv = {w1, w0};
      ad[0] = a0; ad[1] = a1;
      dd[0] = d0; dd[1] = d1;
      #1;
      acc = 1'b0;
      expWe = 1'b0;
      expAddr = '0;
      expWdata = '0;
      if (mOwner >= 0) begin
         acc = rq[mOwner];
         if (acc) begin
            expWe = wv[mOwner];
            expAddr = ad[mOwner];
            expWdata = dd[mOwner];
         end
      end
      checkOutput("mem_we", 32'(mem_we), 32'(expWe));
      checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
      checkOutput("mem_wdata", 32'(mem_wdata), 32'(expWdata));
      checkOutput("stall0", 32'(stall0), 32'(r0 && (mOwner != 0)));
      nRv0 = 1'b0;
      nRv1 = 1'b0;
      if (acc) begin
         if (wv[mOwner]) begin
            refMem[ad[mOwner]] = dd[mOwner];
         end else begin
            mRdata = refMem[ad[mOwner]];
            if (mOwner == 0) nRv0 = 1'b1;
            else nRv1 = 1'b1;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (clr) mWait[k] = 0;
         else if (rq[k] && (mOwner != k) && (mWait[k] < 65535)) mWait[k]++;
      end
      if (mOwner < 0) begin
         if (r0 && r1) nxt = 1 - mLast;
         else if (r0) nxt = 0;
         else if (r1) nxt = 1;
         else nxt = -1;
      end else begin
         o = mOwner;
         p = 1 - o;
         if (!rq[o]) begin
            nxt = rq[p] ? p : -1;
         end else if (rq[p]) begin
            mStreak++;
            nxt = (mStreak >= MAX_HOLD) ? p : o;
         end else begin
            nxt = o;
         end
      end
      if (nxt != mOwner) begin
         mStreak = 0;
         if (nxt >= 0) mLast = nxt;
      end
      mOwner = nxt;
      mRvalid0 = nRv0;
      mRvalid1 = nRv1;
      @(negedge Clk);
      checkOutput("gnt0", 32'(gnt0), 32'(mOwner == 0));
      checkOutput("gnt1", 32'(gnt1), 32'(mOwner == 1));
      checkOutput("rvalid0", 32'(rvalid0), 32'(mRvalid0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(mRvalid1));
      checkOutput("rdata", 32'(rdata), 32'(mRdata));
`ifdef DMEM_ARB_PERF_EN
      checkOutput("wait_cnt0", 32'(waitCnt0), 32'(mWait[0]));
      checkOutput("wait_cnt1", 32'(waitCnt1), 32'(mWait[1]));
`endif
   endtask

   initial begin : mainSeq
      logic          r0, r1;
      logic [AW-1:0] ra0, ra1;
      Reset_n = 1'b0;
      memInit = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef DMEM_ARB_PERF_EN
      perfClr = 1'b0;
`endif
      for (int i = 0; i < 256; i++) refMem[i] = '0;
      resetModel();
      @(negedge Clk);
      memInit = 1'b0;

      // Write 8'hA5 at 8'h10 from the CPU, then read it back
      resetDut();
      applyStimulus(1, 0, 1, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 0);
      checkOutput("wr_gnt0", 32'(gnt0), 32'd1);
      checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
      checkOutput("wr_mem_addr", 32'(mem_addr), 32'h10);
      applyStimulus(1, 0, 1, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 0);
      applyStimulus(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0);
      checkOutput("rd_rvalid0", 32'(rvalid0), 32'd1);
      checkOutput("rd_rdata", 32'(rdata), 32'hA5);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

      // Tie-break alternates with the last-served port
      resetDut();
      applyStimulus(1, 1, 0, 0, 8'h01, 8'h02, 8'h00, 8'h00, 0);
      checkOutput("tie1_gnt0", 32'(gnt0), 32'd1);
      checkOutput("tie1_gnt1", 32'(gnt1), 32'd0);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      applyStimulus(1, 1, 0, 0, 8'h01, 8'h02, 8'h00, 8'h00, 0);
      checkOutput("tie2_gnt1", 32'(gnt1), 32'd1);
      checkOutput("tie2_gnt0", 32'(gnt0), 32'd0);

      // Continuous contention alternates every MAX_HOLD cycles
      resetDut();
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                       8'($urandom), 8'($urandom), 0);
         checkOutput("alt_gnt0", 32'(gnt0), 32'(((k / MAX_HOLD) % 2) == 0));
         checkOutput("alt_both", 32'(gnt0 & gnt1), 32'd0);
      end

      // Uncontested host loader keeps the memory indefinitely
      resetDut();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 1, 0, 1'($urandom_range(0, 1)), 8'h00,
                       8'($urandom_range(0, 15)), 8'h00, 8'($urandom), 0);
         checkOutput("solo_gnt1", 32'(gnt1), 32'd1);
         checkOutput("solo_hold", 32'(dut.uHoldCtr.holdCnt), 32'd0);
      end

      // Reset pulse during a granted read cancels the pending rvalid
      resetDut();
      applyStimulus(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("midrst_gnt0", 32'(gnt0), 32'd0);
      checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
      @(negedge Clk);
      checkOutput("midrst_rvalid0", 32'(rvalid0), 32'd0);
      resetModel();
      Reset_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);

`ifdef DMEM_ARB_PERF_EN
      // Host loader blocked six cycles, then the counters are cleared
      resetDut();
      for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1, 0, 8'h20, 8'h21, 8'h11, 8'h00, 0);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      applyStimulus(1, 0, 1, 0, 8'h22, 8'h00, 8'h33, 8'h00, 0);
      applyStimulus(1, 1, 1, 0, 8'h22, 8'h23, 8'h44, 8'h00, 0);
      checkOutput("perf_wait1", 32'(waitCnt1), 32'd6);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
      checkOutput("perf_clr1", 32'(waitCnt1), 32'd0);
      checkOutput("perf_clr0", 32'(waitCnt0), 32'd0);
`endif

      // Randomized traffic with persistent requests
      resetDut();
      r0 = 1'b0;
      r1 = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) r0 = ~r0;
         if ($urandom_range(0, 3) == 0) r1 = ~r1;
         ra0 = 8'($urandom_range(0, 15));
         ra1 = 8'($urandom_range(0, 15));
         applyStimulus(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ra0, ra1, 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 31) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
